bmf_h_decoder: RTL and testbench

- Streaming, sequential counterpart to the compressor stage of a factorized approximate circuit.
- Accepts K-bit latent words (the "k" signals) over valid/ready and reconstructs M approximate output bits as the Boolean product with a programmable K x M H matrix.
- Sits on the receive side of a partition boundary in an approximate-datapath wrapper.
- Also accumulates error statistics against a supplied exact output, for on-line quality monitoring.

---
 rtl/bmf_pkg.sv | 20 ++
 rtl/bmf_popcount_sat.sv | 45 ++++
 rtl/bmf_h_decoder.sv | 133 +++++++++++++
 tb/tb_bmf_h_decoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bmf_pkg.sv
// Shared types and constants for the BMF H-matrix decoder.
// Combinational helpers only; no latency, no flow control.
// Not applicable: holds no state and sees no backpressure.
package bmf_pkg;

    typedef enum logic [1:0] {
        CFG   = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int SEMIRING_OR  = 0;
    localparam int SEMIRING_XOR = 1;

    // A single-row H still needs a 1-bit index port.
    function automatic int idx_w(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/bmf_popcount_sat.sv
// Popcount of vec_i added into a saturating counter when en_i is high.
// Latency 1: cnt_o reflects the accumulate on the cycle after en_i.
// Never stalls; the counter pins at all-ones instead of wrapping.
module bmf_popcount_sat #(
    parameter int IN_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [IN_W-1:0]  vec_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int PW = $clog2(IN_W + 1);
    localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam logic [SW-1:0] MAXV = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [PW-1:0]    pop;
    logic [SW-1:0]    sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        pop = '0;
        for (int i = 0; i < IN_W; i++) begin
            pop = pop + PW'(vec_i[i]);
        end
        sum   = SW'(cnt_q) + SW'(pop);
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = (sum > MAXV) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/bmf_h_decoder.sv
// Reconstructs M approximate bits from a K-bit latent word via a programmable H matrix.
// Latency 1 from input transfer to out_valid; sustains one word per cycle.
// in_ready drops while the output register is full and not being drained.
module bmf_h_decoder
    import bmf_pkg::*;
#(
    parameter int K        = 1,
    parameter int M        = 4,
    parameter int SEMIRING = SEMIRING_OR,
    parameter int CNT_W    = 16,
    parameter int IDX_W    = idx_w(K)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [M-1:0]     cfg_row,
    input  logic             cfg_clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [K-1:0]     in_k,
    input  logic [M-1:0]     in_exact,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     out_po,
    output logic [CNT_W-1:0] err_words,
    output logic [CNT_W-1:0] err_bits,
    output logic             h_loaded
);

    state_e              state_q, state_d;
    logic [K-1:0][M-1:0] h_q, h_d;
    logic [K-1:0]        mask_q, mask_d;
    logic                out_valid_q, out_valid_d;
    logic [M-1:0]        out_po_q, out_po_d;
    logic [M-1:0]        decoded, diff;
    logic                xfer;

    assign cfg_ready = (state_q == CFG);
    assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
    assign xfer      = in_valid && in_ready;
    assign diff      = decoded ^ in_exact;

    always_comb begin
        decoded = '0;
        for (int i = 0; i < K; i++) begin
            if (in_k[i]) begin
                if (SEMIRING == SEMIRING_XOR) decoded = decoded ^ h_q[i];
                else                          decoded = decoded | h_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        mask_d      = mask_q;
        out_valid_d = out_valid_q;
        out_po_d    = out_po_q;

        if (xfer) begin
            out_valid_d = 1'b1;
            out_po_d    = decoded;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            CFG: begin
                // Out-of-range indices match no row and are silently dropped.
                if (cfg_valid) begin
                    for (int i = 0; i < K; i++) begin
                        if (int'(cfg_idx) == i) begin
                            h_d[i]    = cfg_row;
                            mask_d[i] = 1'b1;
                        end
                    end
                end
                if (cfg_clear) mask_d = '0;
                if (&mask_d) state_d = RUN;
            end
            RUN: begin
                if (cfg_clear) begin
                    mask_d  = '0;
                    state_d = (out_valid_q || xfer) ? DRAIN : CFG;
                end
            end
            DRAIN: begin
                if (!out_valid_q) state_d = CFG;
            end
            default: state_d = CFG;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CFG;
            h_q         <= '0;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            out_po_q    <= '0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            out_po_q    <= out_po_d;
        end
    end

    // Statistics survive cfg_clear; only rst_n zeroes them.
    bmf_popcount_sat #(.IN_W(M), .CNT_W(CNT_W)) u_err_bits (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (xfer),
        .vec_i (diff),
        .cnt_o (err_bits)
    );

    bmf_popcount_sat #(.IN_W(1), .CNT_W(CNT_W)) u_err_words (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (xfer),
        .vec_i (|diff),
        .cnt_o (err_words)
    );

    assign out_valid = out_valid_q;
    assign out_po    = out_po_q;
    assign h_loaded  = (state_q == RUN);

endmodule

// File: tb/tb_bmf_h_decoder.sv
// Drives an OR-semiring and an XOR-semiring decoder from shared stimulus
// and checks both against hand-computed expectations.
module tb_bmf_h_decoder;

    localparam int K     = 3;
    localparam int M     = 4;
    localparam int CNT_W = 4;
    localparam int IW    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          cfg_valid, cfg_clear, in_valid, out_ready;
    logic [IW-1:0] cfg_idx;
    logic [M-1:0]  cfg_row, in_exact;
    logic [K-1:0]  in_k;

    logic             o_cfg_ready, o_in_ready, o_out_valid, o_h_loaded;
    logic [M-1:0]     o_po;
    logic [CNT_W-1:0] o_words, o_bits;
    logic             x_cfg_ready, x_in_ready, x_out_valid, x_h_loaded;
    logic [M-1:0]     x_po;
    logic [CNT_W-1:0] x_words, x_bits;

    int checks = 0;
    int errors = 0;

    bmf_h_decoder #(.K(K), .M(M), .SEMIRING(0), .CNT_W(CNT_W)) u_or (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(o_cfg_ready), .cfg_idx(cfg_idx),
        .cfg_row(cfg_row), .cfg_clear(cfg_clear),
        .in_valid(in_valid), .in_ready(o_in_ready), .in_k(in_k), .in_exact(in_exact),
        .out_valid(o_out_valid), .out_ready(out_ready), .out_po(o_po),
        .err_words(o_words), .err_bits(o_bits), .h_loaded(o_h_loaded)
    );

    bmf_h_decoder #(.K(K), .M(M), .SEMIRING(1), .CNT_W(CNT_W)) u_xor (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(x_cfg_ready), .cfg_idx(cfg_idx),
        .cfg_row(cfg_row), .cfg_clear(cfg_clear),
        .in_valid(in_valid), .in_ready(x_in_ready), .in_k(in_k), .in_exact(in_exact),
        .out_valid(x_out_valid), .out_ready(out_ready), .out_po(x_po),
        .err_words(x_words), .err_bits(x_bits), .h_loaded(x_h_loaded)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic vld, input logic [M-1:0] opo,
                           input logic [M-1:0] xpo);
        chk({tag, "_or_vld"},  32'(o_out_valid), 32'(vld));
        chk({tag, "_xor_vld"}, 32'(x_out_valid), 32'(vld));
        chk({tag, "_or_po"},   32'(o_po), 32'(opo));
        chk({tag, "_xor_po"},  32'(x_po), 32'(xpo));
    endtask

    task automatic chk_cnt(input string tag, input int ow, input int ob, input int xw,
                           input int xb);
        chk({tag, "_or_words"},  32'(o_words), 32'(ow));
        chk({tag, "_or_bits"},   32'(o_bits),  32'(ob));
        chk({tag, "_xor_words"}, 32'(x_words), 32'(xw));
        chk({tag, "_xor_bits"},  32'(x_bits),  32'(xb));
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_clear = 1'b0;
        cfg_idx   = '0;
        cfg_row   = '0;
        in_valid  = 1'b0;
        in_k      = '0;
        in_exact  = '0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk_out("rst", 1'b0, 4'b0000, 4'b0000);
        chk_cnt("rst", 0, 0, 0, 0);
        chk("rst_h_loaded", 32'(o_h_loaded), 32'd0);
        chk("rst_cfg_ready", 32'(o_cfg_ready), 32'd1);

        @(negedge clk);
        rst_n = 1'b1;

        // Input is refused until every row of H is present.
        in_valid = 1'b1; in_k = 3'b001;
        cfg_valid = 1'b1; cfg_idx = 2'd0; cfg_row = 4'b0011;
        #1;
        chk("gate_in_ready0", 32'(o_in_ready), 32'd0);
        step();
        cfg_idx = 2'd3; cfg_row = 4'b1111;
        step();
        chk("gate_idx3_h_loaded", 32'(o_h_loaded), 32'd0);
        chk("gate_in_ready1", 32'(x_in_ready), 32'd0);
        cfg_idx = 2'd1; cfg_row = 4'b0110;
        step();
        chk("gate_row1_h_loaded", 32'(x_h_loaded), 32'd0);
        chk("gate_out_valid", 32'(o_out_valid), 32'd0);
        in_valid = 1'b0;
        cfg_idx = 2'd2; cfg_row = 4'b1000;
        step();
        cfg_valid = 1'b0;
        chk("load_or_h_loaded", 32'(o_h_loaded), 32'd1);
        chk("load_xor_h_loaded", 32'(x_h_loaded), 32'd1);
        chk("load_cfg_ready", 32'(o_cfg_ready), 32'd0);

        // H = {row0 0011, row1 0110, row2 1000}
        in_valid = 1'b1; in_k = 3'b011; in_exact = 4'b0101;
        step();
        chk_out("k011", 1'b1, 4'b0111, 4'b0101);
        chk_cnt("k011", 1, 1, 0, 0);

        in_k = 3'b100; in_exact = 4'b1000;
        cfg_valid = 1'b1; cfg_idx = 2'd2; cfg_row = 4'b1111;
        step();
        chk_out("k100", 1'b1, 4'b1000, 4'b1000);

        cfg_valid = 1'b0;
        in_k = 3'b000; in_exact = 4'b0010;
        step();
        chk_out("k000", 1'b1, 4'b0000, 4'b0000);
        chk_cnt("k000", 2, 2, 1, 1);

        in_k = 3'b111; in_exact = 4'b0000;
        step();
        chk_out("k111", 1'b1, 4'b1111, 4'b1101);
        chk_cnt("k111", 3, 6, 2, 4);

        // Backpressure: full output register and no drain stalls input.
        out_ready = 1'b0; in_k = 3'b001; in_exact = 4'b0011;
        #1;
        chk("bp_in_ready", 32'(o_in_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk_out("bp_hold", 1'b1, 4'b1111, 4'b1101);
            chk("bp_in_ready_hold", 32'(x_in_ready), 32'd0);
        end
        chk_cnt("bp_hold", 3, 6, 2, 4);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(o_in_ready), 32'd1);
        step();
        chk_out("bp_w1", 1'b1, 4'b0011, 4'b0011);
        in_k = 3'b010; in_exact = 4'b0110;
        step();
        chk_out("bp_w2", 1'b1, 4'b0110, 4'b0110);
        in_valid = 1'b0;
        step();
        chk("bp_empty_or", 32'(o_out_valid), 32'd0);
        chk("bp_empty_xor", 32'(x_out_valid), 32'd0);
        chk_cnt("bp_done", 3, 6, 2, 4);

        // Clear with a word parked at the output.
        in_valid = 1'b1; in_k = 3'b100; in_exact = 4'b1000;
        step();
        in_valid = 1'b0; out_ready = 1'b0; cfg_clear = 1'b1;
        step();
        cfg_clear = 1'b0;
        in_valid = 1'b1;
        #1;
        chk("drain_cfg_ready", 32'(o_cfg_ready), 32'd0);
        chk("drain_h_loaded", 32'(o_h_loaded), 32'd0);
        chk("drain_in_ready", 32'(x_in_ready), 32'd0);
        chk_out("drain_hold", 1'b1, 4'b1000, 4'b1000);
        step();
        chk("drain_cfg_ready2", 32'(x_cfg_ready), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("drain_out_valid", 32'(o_out_valid), 32'd0);
        chk("drain_cfg_ready3", 32'(o_cfg_ready), 32'd0);
        step();
        chk("cfg_back_cfg_ready", 32'(o_cfg_ready), 32'd1);
        chk("cfg_back_h_loaded", 32'(x_h_loaded), 32'd0);
        chk_cnt("clear_keep", 3, 6, 2, 4);

        // Reload and drive the counters into saturation.
        cfg_valid = 1'b1;
        cfg_idx = 2'd0; cfg_row = 4'b0001; step();
        cfg_idx = 2'd1; cfg_row = 4'b0010; step();
        cfg_idx = 2'd2; cfg_row = 4'b0100; step();
        cfg_valid = 1'b0;
        chk("reload_h_loaded", 32'(o_h_loaded), 32'd1);
        in_valid = 1'b1; in_k = 3'b001; in_exact = 4'b0000;
        for (int n = 0; n < 20; n++) step();
        chk_out("sat", 1'b1, 4'b0001, 4'b0001);
        chk_cnt("sat", 15, 15, 15, 15);

        // Asynchronous reset in the middle of the stream.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("arst", 1'b0, 4'b0000, 4'b0000);
        chk_cnt("arst", 0, 0, 0, 0);
        chk("arst_h_loaded", 32'(o_h_loaded), 32'd0);
        chk("arst_in_ready", 32'(o_in_ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
